// File: rtl/reg_file_bank.sv
// reg_file_bank: DEPTH x WIDTH operand register file, one write port and two
// registered read ports with write bypass, plus a sequenced clear-all.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | normal operation, writes accepted, busy low
// S_CLEAR | zeroing entry idx_q each edge, writes blocked, busy high
module reg_file_bank #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             write,
  input  logic [AW-1:0]    reg_num,
  input  logic [WIDTH-1:0] op,
  input  logic [AW-1:0]    reg_sel_a,
  input  logic [AW-1:0]    reg_sel_b,
  input  logic             clear,
  output logic [WIDTH-1:0] reg_val_a,
  output logic [WIDTH-1:0] reg_val_b,
  output logic             busy
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH);

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] mem_q [1:DEPTH];
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             wr_en, clr_en;
  logic             sel_a_ok, sel_b_ok;

  // Address 0 and anything above DEPTH are null addresses.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (a <= LAST_IDX);
  endfunction

  assign wr_en    = (state_q == S_IDLE) && write && addr_ok(reg_num);
  assign clr_en   = (state_q == S_CLEAR);
  assign sel_a_ok = addr_ok(reg_sel_a);
  assign sel_b_ok = addr_ok(reg_sel_b);
  assign busy     = clr_en;

  // Clear sequencer: next state and entry index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d = S_CLEAR;
          idx_d   = AW'(1);
        end
      end
      S_CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Storage: write in idle, or zero the entry under the clear index.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 1; i <= DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 1; i <= DEPTH; i++) begin
        if (wr_en && (reg_num == AW'(i)))
          mem_q[i] <= op;
        else if (clr_en && (idx_q == AW'(i)))
          mem_q[i] <= '0;
      end
    end
  end

  // Raw read muxes from stored contents.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      if (reg_sel_a == AW'(i)) rd_a = mem_q[i];
      if (reg_sel_b == AW'(i)) rd_b = mem_q[i];
    end
  end

  // Registered read ports; the entry's post-edge value wins via bypass.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      reg_val_a <= '0;
      reg_val_b <= '0;
    end else begin
      if (sel_a_ok) begin
        if (clr_en && (reg_sel_a == idx_q))
          reg_val_a <= '0;
        else if (wr_en && (reg_sel_a == reg_num))
          reg_val_a <= op;
        else
          reg_val_a <= rd_a;
      end
      if (sel_b_ok) begin
        if (clr_en && (reg_sel_b == idx_q))
          reg_val_b <= '0;
        else if (wr_en && (reg_sel_b == reg_num))
          reg_val_b <= op;
        else
          reg_val_b <= rd_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// Bench for reg_file_bank: directed scenarios followed by random traffic,
// every cycle checked against an entry-level reference model.
module tb_reg_file_bank;
  localparam int WIDTH = 9;
  localparam int DEPTH = 4;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             nrst;
  logic             write;
  logic [AW-1:0]    reg_num;
  logic [WIDTH-1:0] op;
  logic [AW-1:0]    reg_sel_a;
  logic [AW-1:0]    reg_sel_b;
  logic             clear;
  logic [WIDTH-1:0] reg_val_a;
  logic [WIDTH-1:0] reg_val_b;
  logic             busy;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] m_mem [1:DEPTH];
  logic [WIDTH-1:0] exp_a, exp_b;
  int               clr_pos;

  reg_file_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .nrst(nrst), .write(write), .reg_num(reg_num), .op(op),
    .reg_sel_a(reg_sel_a), .reg_sel_b(reg_sel_b), .clear(clear),
    .reg_val_a(reg_val_a), .reg_val_b(reg_val_b), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 1; i <= DEPTH; i++) m_mem[i] = '0;
    exp_a = '0;
    exp_b = '0;
    clr_pos = 0;
  endtask

  // One rising edge: the entry's content after the edge is what a valid
  // read port shows, so bypass falls out of applying updates first.
  task automatic model_edge();
    int n, sa, sb;
    n  = int'(reg_num);
    sa = int'(reg_sel_a);
    sb = int'(reg_sel_b);
    if (clr_pos != 0) m_mem[clr_pos] = '0;
    if (clr_pos == 0 && write && n >= 1 && n <= DEPTH) m_mem[n] = op;
    if (sa >= 1 && sa <= DEPTH) exp_a = m_mem[sa];
    if (sb >= 1 && sb <= DEPTH) exp_b = m_mem[sb];
    if (clr_pos == 0) begin
      if (clear) clr_pos = 1;
    end else if (clr_pos == DEPTH) begin
      clr_pos = 0;
    end else begin
      clr_pos = clr_pos + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_a"}, 16'(reg_val_a), 16'(exp_a));
    chk({tag, "_b"}, 16'(reg_val_b), 16'(exp_b));
    chk({tag, "_busy"}, 16'(busy), 16'(clr_pos != 0));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_write(input int n, input int v);
    write = 1'b1;
    reg_num = AW'(n);
    op = WIDTH'(v);
    step("wr");
    write = 1'b0;
  endtask

  initial begin
    nrst = 1'b0;
    write = 1'b0;
    reg_num = '0;
    op = '0;
    reg_sel_a = AW'(1);
    reg_sel_b = AW'(4);
    clear = 1'b0;
    model_reset();
    #12;
    chk("reset_a", 16'(reg_val_a), 16'h0);
    chk("reset_b", 16'(reg_val_b), 16'h0);
    chk("reset_busy", 16'(busy), 16'h0);
    nrst = 1'b1;
    step("idle");

    // write then read on both ports, null select holds
    do_write(2, 9'h1A5);
    do_write(3, 9'h055);
    reg_sel_a = AW'(2);
    reg_sel_b = AW'(3);
    step("rd");
    chk("rd_a_const", 16'(reg_val_a), 16'h1A5);
    chk("rd_b_const", 16'(reg_val_b), 16'h055);
    reg_sel_a = '0;
    step("hold");
    chk("hold_a_const", 16'(reg_val_a), 16'h1A5);

    // bypass on both ports, then writes to null addresses
    do_write(1, 9'h00F);
    reg_sel_a = AW'(1);
    reg_sel_b = AW'(1);
    do_write(1, 9'h1F0);
    chk("byp_a_const", 16'(reg_val_a), 16'h1F0);
    chk("byp_b_const", 16'(reg_val_b), 16'h1F0);
    do_write(0, 9'h1FF);
    do_write(5, 9'h1EE);
    for (int i = 1; i <= DEPTH; i++) begin
      reg_sel_a = AW'(i);
      reg_sel_b = AW'(DEPTH + 1 - i);
      step("scan1");
    end

    // clear sequence with a blocked write in the middle
    for (int i = 1; i <= DEPTH; i++) do_write(i, i);
    reg_sel_a = AW'(4);
    reg_sel_b = AW'(2);
    clear = 1'b1;
    step("clr_e0");
    clear = 1'b0;
    chk("clr_e0_a_const", 16'(reg_val_a), 16'h4);
    step("clr_e1");
    reg_sel_b = AW'(1);
    write = 1'b1;
    reg_num = AW'(1);
    op = 9'h077;
    step("clr_e2");
    write = 1'b0;
    chk("clr_blockwr_b_const", 16'(reg_val_b), 16'h0);
    step("clr_e3");
    chk("clr_e3_a_const", 16'(reg_val_a), 16'h4);
    chk("clr_e3_busy_const", 16'(busy), 16'h1);
    write = 1'b1;
    reg_num = AW'(2);
    op = 9'h0AA;
    step("clr_e4");
    write = 1'b0;
    chk("clr_e4_a_const", 16'(reg_val_a), 16'h0);
    chk("clr_e4_busy_const", 16'(busy), 16'h0);
    for (int i = 1; i <= DEPTH; i++) begin
      reg_sel_a = AW'(i);
      reg_sel_b = AW'(i);
      step("scan2");
    end

    // clear together with a write, and a second clear mid-sequence
    reg_sel_a = AW'(3);
    reg_sel_b = AW'(4);
    write = 1'b1;
    reg_num = AW'(3);
    op = 9'h011;
    clear = 1'b1;
    step("cw_e0");
    write = 1'b0;
    clear = 1'b0;
    chk("cw_e0_a_const", 16'(reg_val_a), 16'h011);
    step("cw_e1");
    clear = 1'b1;
    step("cw_e2");
    clear = 1'b0;
    step("cw_e3");
    chk("cw_e3_a_const", 16'(reg_val_a), 16'h0);
    step("cw_e4");
    chk("cw_e4_busy_const", 16'(busy), 16'h0);
    step("cw_after");

    // reset in the middle of a clear
    for (int i = 1; i <= DEPTH; i++) do_write(i, 9'h100 + i);
    reg_sel_a = AW'(4);
    reg_sel_b = AW'(3);
    clear = 1'b1;
    step("rc_e0");
    clear = 1'b0;
    step("rc_e1");
    step("rc_e2");
    nrst = 1'b0;
    #1;
    model_reset();
    chk("rc_rst_a", 16'(reg_val_a), 16'h0);
    chk("rc_rst_b", 16'(reg_val_b), 16'h0);
    chk("rc_rst_busy", 16'(busy), 16'h0);
    #3;
    nrst = 1'b1;
    step("rc_idle");
    reg_sel_a = AW'(2);
    do_write(2, 9'h0C3);
    chk("rc_wr_const", 16'(reg_val_a), 16'h0C3);
    reg_sel_a = AW'(4);
    step("rc_cleared");

    // random traffic
    for (int k = 0; k < 600; k++) begin
      write     = 1'($urandom_range(0, 1));
      reg_num   = AW'($urandom_range(0, 7));
      op        = WIDTH'($urandom);
      reg_sel_a = AW'($urandom_range(0, 7));
      reg_sel_b = AW'($urandom_range(0, 7));
      clear     = ($urandom_range(0, 15) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
